lm_sm_sequencer: RTL
====================

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 Parameter ADDR_STEP, default 16'd1, SHALL be the address increment between consecutive memory micro-ops.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 flush  input  1  pipeline flush; discards any in-progress sequence.
REQ-005 instr_valid  input  1  instr and ra_data are valid this cycle.
REQ-006 instr  input  16  fetched instruction: [15:12] opcode, [11:9] RA, [7:0] register mask.
REQ-007 ra_data  input  16  base address, i.e. the value of RA, qualified by instr_valid.
REQ-008 instr_accept  output  1  combinational; the LM/SM instruction is taken this cycle.
REQ-009 busy  output  1  registered; sequence in progress; upstream SHALL hold fetch/decode.
REQ-010 uop_valid  output  1  micro-op presented.
REQ-011 uop_ready  input  1  downstream takes the micro-op.
REQ-012 uop_is_store  output  1  1 = SM (register to memory), 0 = LM (memory to register).
REQ-013 uop_reg  output  3  register index for this micro-op.
REQ-014 uop_addr  output  16  memory address for this micro-op.
REQ-015 uop_last  output  1  this is the final micro-op of the sequence.
REQ-016 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-017 Opcodes SHALL be LM = 4'b0110 and SM = 4'b0111; all other opcodes SHALL leave instr_accept at 0 and cause no state change.
REQ-018 States SHALL be IDLE and ISSUE.
REQ-019 instr_accept SHALL equal (state==IDLE) & instr_valid & opcode is LM or SM & !flush.
REQ-020 On accept with a nonzero mask, at the next edge the block SHALL latch mask, ra_data and the LM/SM kind, clear the micro-op count, and enter ISSUE.
REQ-021 On accept with mask==0, the block SHALL stay in IDLE, issue no micro-op, and pulse done in the following cycle.
REQ-022 In ISSUE, uop_valid SHALL be 1, so the first micro-op appears one cycle after accept.
REQ-023 uop_reg SHALL be the index of the lowest set bit of the remaining mask, where mask bit i selects Ri.
REQ-024 uop_addr SHALL equal base + count*ADDR_STEP, computed modulo 2^16 so that it wraps through 16'hFFFF to 16'h0000.
REQ-025 uop_last SHALL be 1 exactly when the remaining mask has one set bit.
REQ-026 A transfer SHALL occur on uop_valid & uop_ready; on each transfer the block SHALL clear the issued mask bit and increment the count.
REQ-027 If uop_ready is 0, uop_reg, uop_addr, uop_is_store and uop_last SHALL stay stable.
REQ-028 On the transfer with uop_last=1, the block SHALL return to IDLE and pulse done in the next cycle.
REQ-029 busy SHALL equal (state==ISSUE).
REQ-030 A back-to-back LM/SM SHALL be acceptable in the first cycle after return to IDLE.
REQ-031 When flush=1, at the next edge the block SHALL enter IDLE, clear mask and count, and suppress done.
REQ-032 flush SHALL take priority over a simultaneous transfer or accept.
REQ-033 A mask of 8'hFF SHALL produce 8 micro-ops R0..R7 at base .. base+7*ADDR_STEP.

Reset
REQ-034 While reset=1: state=IDLE, mask=0, count=0, base=0, uop_valid=0, done=0, busy=0, uop_reg=0, uop_addr=0, uop_is_store=0, uop_last=0.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence immediately, without waiting for a clock edge, and SHALL produce no done pulse.

Structure
REQ-036 OPC_LM, OPC_SM and the state encoding SHALL reside in the shared ISA package.
REQ-037 The lowest-set-bit encoder SHALL be a sub-module named prio_enc8 with inputs mask[7:0] and outputs idx[2:0] and one_hot_single.

Verification
REQ-038 Bench: LM, mask 8'b0000_0101, ra_data=16'h0010, uop_ready=1 -> uops (R0,16'h0010), (R2,16'h0011 with last=1), then done.
REQ-039 Bench: SM, mask 8'hFF, uop_ready toggled 1/0 -> 8 stores R0..R7 at addresses 0x0020..0x0027, outputs stable while stalled, busy high throughout.
REQ-040 Bench: LM, mask 8'h00 -> accept, no uop_valid, done one cycle later.
REQ-041 Bench: SM, mask 8'b1100_0000, ra_data=16'hFFFF -> (R6,16'hFFFF), (R7,16'h0000 with last=1).
REQ-042 Bench: flush asserted after the 2nd transfer of a 4-bit mask -> IDLE next cycle, no done, and the next LM is accepted.
REQ-043 Bench: reset asserted mid-ISSUE between clock edges -> uop_valid and busy drop at once, and no done pulse.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared ISA definitions for the LM/SM multi-register load/store sequencer.
// Holds the opcode encodings and the sequencer state encoding.
package lm_sm_sequencer_pkg;

  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/lm_sm_sequencer_prio_enc8.sv
// Lowest-set-bit encoder for an 8-bit register mask.
// one_hot_single flags that exactly one bit remains set.
module prio_enc8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       one_hot_single
);

  // Scan from the top so the lowest set bit is the one left standing.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign one_hot_single = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands an LM/SM instruction into one memory micro-op per set mask bit,
// lowest register first, at consecutive addresses from the RA base.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [15:0] ra_data,
  output logic        instr_accept,
  output logic        busy,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic        uop_is_store,
  output logic [2:0]  uop_reg,
  output logic [15:0] uop_addr,
  output logic        uop_last,
  output logic        done
);

  state_t      state, state_n;
  logic [7:0]  mask_r, mask_n;
  logic [3:0]  count_r, count_n;
  logic [15:0] base_r, base_n;
  logic        store_r, store_n;
  logic        done_r, done_n;

  logic [3:0]  opcode;
  logic        is_lmsm;
  logic [2:0]  low_idx;
  logic        single_left;
  logic        instr_unused;

  function automatic logic [15:0] uop_offset(input logic [3:0] cnt);
    return 16'(cnt) * ADDR_STEP;
  endfunction

  assign opcode       = instr[15:12];
  assign is_lmsm      = (opcode == OPC_LM) || (opcode == OPC_SM);
  // RA is resolved upstream into ra_data; the field itself is not needed here.
  assign instr_unused = ^instr[11:8];

  prio_enc8 u_prio_enc8 (
    .mask           (mask_r),
    .idx            (low_idx),
    .one_hot_single (single_left)
  );

  assign instr_accept = (state == S_IDLE) && instr_valid && is_lmsm && !flush;
  assign busy         = (state == S_ISSUE);
  assign uop_valid    = (state == S_ISSUE);
  assign uop_is_store = store_r;
  assign uop_reg      = low_idx;
  assign uop_addr     = base_r + uop_offset(count_r);
  assign uop_last     = single_left;
  assign done         = done_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      mask_r  <= 8'd0;
      count_r <= 4'd0;
      base_r  <= 16'd0;
      store_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      mask_r  <= mask_n;
      count_r <= count_n;
      base_r  <= base_n;
      store_r <= store_n;
      done_r  <= done_n;
    end
  end

  // Flush wins over both a new accept and an in-flight transfer.
  always_comb begin
    state_n = state;
    mask_n  = mask_r;
    count_n = count_r;
    base_n  = base_r;
    store_n = store_r;
    done_n  = 1'b0;
    if (flush) begin
      state_n = S_IDLE;
      mask_n  = 8'd0;
      count_n = 4'd0;
    end else if (instr_accept) begin
      if (instr[7:0] != 8'd0) begin
        state_n = S_ISSUE;
        mask_n  = instr[7:0];
        count_n = 4'd0;
        base_n  = ra_data;
        store_n = (opcode == OPC_SM);
      end else begin
        done_n  = 1'b1;
      end
    end else if ((state == S_ISSUE) && uop_ready) begin
      mask_n  = mask_r & (mask_r - 8'd1);
      count_n = count_r + 4'd1;
      if (single_left) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

endmodule
